// File: rtl/simd_register_file.sv
// rtl/simd_register_file.sv - 32x128 SIMD register file doubling as the ID/EX operand register
// Optional same-edge write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module simd_register_file #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 128,
    parameter int INSTR_W  = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_id,
    input  logic               hold,
    input  logic               we,
    input  logic [ADDR_W-1:0]  rd,
    input  logic [DATA_W-1:0]  data_wb,
    output logic [INSTR_W-1:0] instr_ex,
    output logic [DATA_W-1:0]  rs1_data,
    output logic [DATA_W-1:0]  rs2_data,
    output logic [DATA_W-1:0]  rs3_data,
    output logic [15:0]        wb_count,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(25'h1800000);

    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [INSTR_W-1:0] r_instr_ex;
    logic [DATA_W-1:0]  r_rs1_data;
    logic [DATA_W-1:0]  r_rs2_data;
    logic [DATA_W-1:0]  r_rs3_data;
    logic [15:0]        r_wb_count;

    logic [ADDR_W-1:0]  w_rs1_addr;
    logic [ADDR_W-1:0]  w_rs2_addr;
    logic [ADDR_W-1:0]  w_rs3_addr;
    logic [DATA_W-1:0]  w_op1;
    logic [DATA_W-1:0]  w_op2;
    logic [DATA_W-1:0]  w_op3;

    assign w_rs1_addr = instr_id[9:5];
    assign w_rs2_addr = instr_id[14:10];
    assign w_rs3_addr = instr_id[19:15];

    // Operands come from the pre-edge array; the bypass build substitutes the write-back value.
    always_comb begin
        w_op1 = r_regs[w_rs1_addr];
        w_op2 = r_regs[w_rs2_addr];
        w_op3 = r_regs[w_rs3_addr];
`ifdef RF_BYPASS_EN
        if (we && (rd == w_rs1_addr)) w_op1 = data_wb;
        if (we && (rd == w_rs2_addr)) w_op2 = data_wb;
        if (we && (rd == w_rs3_addr)) w_op3 = data_wb;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[rd] <= data_wb;
        end
    end

    // Writes proceed during a stall; only the ID/EX outputs freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_ex <= NOP_INSTR;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs3_data <= '0;
        end else if (!hold) begin
            r_instr_ex <= instr_id;
            r_rs1_data <= w_op1;
            r_rs2_data <= w_op2;
            r_rs3_data <= w_op3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_count <= '0;
        end else if (we && (r_wb_count != 16'hFFFF)) begin
            r_wb_count <= r_wb_count + 16'd1;
        end
    end

    assign instr_ex = r_instr_ex;
    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
    assign rs3_data = r_rs3_data;
    assign wb_count = r_wb_count;
    assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_simd_register_file.sv
// tb/tb_simd_register_file.sv - scoreboard bench for simd_register_file against an array model
module tb_simd_register_file;

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [24:0] NOP = 25'h1800000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [24:0]  instr_id = '0;
    logic         hold = 1'b0;
    logic         we = 1'b0;
    logic [4:0]   rd = '0;
    logic [127:0] data_wb = '0;
    logic [24:0]  instr_ex;
    logic [127:0] rs1_data, rs2_data, rs3_data;
    logic [15:0]  wb_count;
    logic [4:0]   dbg_addr = '0;
    logic [127:0] dbg_data;

    simd_register_file dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .hold(hold), .we(we), .rd(rd),
        .data_wb(data_wb), .instr_ex(instr_ex), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs3_data(rs3_data), .wb_count(wb_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0]  instr;
        logic [127:0] op1;
        logic [127:0] op2;
        logic [127:0] op3;
        logic [15:0]  cnt;
        logic [127:0] dbg;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] m_regs [32];
    exp_t         m_out;
    int           m_cnt = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic logic [24:0] mk_instr(input logic [4:0] a1, input logic [4:0] a2,
                                             input logic [4:0] a3);
        logic [24:0] v;
        v        = 25'($urandom);
        v[9:5]   = a1;
        v[14:10] = a2;
        v[19:15] = a3;
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] model_read(input logic [4:0] a, input logic w,
                                                input logic [4:0] wa, input logic [127:0] wd);
        if (BYPASS && w && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    // Drive one cycle's inputs mid-cycle and push what the outputs must show after the next edge.
    task automatic step(input logic r, input logic h, input logic w, input logic [4:0] wa,
                        input logic [127:0] wd, input logic [24:0] ins, input logic [4:0] da);
        @(negedge clk);
        rst = r; hold = h; we = w; rd = wa; data_wb = wd; instr_id = ins; dbg_addr = da;
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_out.instr = NOP;
            m_out.op1 = '0; m_out.op2 = '0; m_out.op3 = '0;
            m_cnt = 0;
        end else begin
            if (!h) begin
                m_out.instr = ins;
                m_out.op1 = model_read(ins[9:5], w, wa, wd);
                m_out.op2 = model_read(ins[14:10], w, wa, wd);
                m_out.op3 = model_read(ins[19:15], w, wa, wd);
            end
            if (w) begin
                m_regs[wa] = wd;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        m_out.cnt = 16'(m_cnt);
        m_out.dbg = m_regs[da];
        exp_q.push_back(m_out);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("instr_ex", 128'(instr_ex), 128'(e.instr));
            check("rs1_data", rs1_data, e.op1);
            check("rs2_data", rs2_data, e.op2);
            check("rs3_data", rs3_data, e.op3);
            check("wb_count", 128'(wb_count), 128'(e.cnt));
            check("dbg_data", dbg_data, e.dbg);
        end
    end

    initial begin
        logic [127:0] val_a, val_b;
        foreach (m_regs[i]) m_regs[i] = '0;
        m_out = '0;

        // Reset applied mid-cycle with a write pending, then dump every register.
        step(1, 0, 1, 5'd3, '1, mk_instr(5'd3, 5'd3, 5'd3), 5'd3);
        step(1, 0, 1, 5'd3, '1, mk_instr(5'd3, 5'd3, 5'd3), 5'd3);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 5'd0, '0, NOP, 5'(i));

        // Basic write then read of the same register.
        step(0, 0, 1, 5'd7, 128'h0123456789ABCDEF0123456789ABCDEF, NOP, 5'd7);
        step(0, 0, 0, 5'd0, '0, mk_instr(5'd7, 5'd0, 5'd1), 5'd7);

        // Same-edge hazard on rs2, then a re-read.
        val_b = rand128();
        val_a = rand128();
        step(0, 0, 1, 5'd5, val_b, NOP, 5'd5);
        step(0, 0, 1, 5'd5, val_a, mk_instr(5'd1, 5'd5, 5'd2), 5'd5);
        step(0, 0, 0, 5'd0, '0, mk_instr(5'd1, 5'd5, 5'd2), 5'd5);

        // All three fields on one register.
        step(0, 0, 1, 5'd9, 128'hFF00, NOP, 5'd9);
        step(0, 0, 0, 5'd0, '0, mk_instr(5'd9, 5'd9, 5'd9), 5'd9);

        // Stall while writing, then release and read the written register.
        step(0, 0, 0, 5'd0, '0, mk_instr(5'd4, 5'd6, 5'd8), 5'd2);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd2, 128'h5A, mk_instr(5'd2, 5'd2, 5'd2), 5'd2);
        step(0, 0, 0, 5'd0, '0, mk_instr(5'd2, 5'd3, 5'd4), 5'd2);

        // Random traffic on a narrow address range to provoke hazards; occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
                 5'($urandom_range(0, 7)), rand128(),
                 mk_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7))), 5'($urandom));
        end

        // Push the write counter through its saturation point.
        for (int i = 0; i < 65540; i++) begin
            step(0, 1'($urandom), 1, 5'($urandom), rand128(),
                 mk_instr(5'($urandom), 5'($urandom), 5'($urandom)), 5'($urandom));
        end
        step(0, 0, 0, 5'd0, '0, NOP, 5'd0);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
